// File: rtl/cpu_mux_pkg.sv
// Shared definitions for the CPU datapath selectors: legacy select codes,
// the default output depth, and a helper that sizes a select from an input count.
package cpu_mux_pkg;

  localparam int SEL_ALURESULT  = 0;
  localparam int SEL_ALUOUT     = 1;
  localparam int SEL_PC         = 2;

  localparam int DEFAULT_STAGES = 1;

  // Minimum select width able to address n inputs (never below 1 bit).
  function automatic int sel_w_for(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One output register of the selector pipeline: data, select tag and valid,
// with asynchronous reset and a hold-on-stall enable.
module mux_pipe_stage #(
  parameter int bitwidth = 32,
  parameter int sel_w    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [bitwidth-1:0] d_nxt,
  input  logic                v_nxt,
  input  logic [sel_w-1:0]    s_nxt,
  output logic [bitwidth-1:0] d_q,
  output logic                v_q,
  output logic [sel_w-1:0]    s_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
      v_q <= 1'b0;
      s_q <= '0;
    end else if (en) begin
      d_q <= d_nxt;
      v_q <= v_nxt;
      s_q <= s_nxt;
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-way datapath selector with 1- or 2-deep output pipeline,
// valid/stall handling and a sticky flag for out-of-range selects.
module mux_n_pipe
  import cpu_mux_pkg::*;
#(
  parameter int                bitwidth    = 32,
  parameter int                num_in      = 4,
  parameter int                sel_w       = 2,
  parameter int                stages      = DEFAULT_STAGES,
  parameter logic [bitwidth-1:0] default_val = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [sel_w-1:0]           sel,
  input  logic [num_in*bitwidth-1:0] in_bus,
  input  logic                       err_clr,
  output logic [bitwidth-1:0]        out,
  output logic                       out_valid,
  output logic [sel_w-1:0]           sel_q,
  output logic                       err_sticky
);

  if (stages < 1 || stages > 2) begin : g_bad_stages
    $error("mux_n_pipe: stages must be 1 or 2");
  end
  if (num_in < 2 || num_in > 16 || (1 << sel_w) < num_in) begin : g_bad_sel_w
    $error("mux_n_pipe: num_in must be 2..16 and fit in sel_w bits");
  end

  // Extra bit lets the range compare work even when num_in == 2**sel_w.
  localparam logic [sel_w:0] NUM_IN_C = (sel_w+1)'(num_in);

  logic [bitwidth-1:0] pick;
  logic                oor;

  always_comb begin
    pick = default_val;
    for (int i = 0; i < num_in; i++) begin
      if (sel == sel_w'(i)) pick = in_bus[i*bitwidth +: bitwidth];
    end
  end

  assign oor = ({1'b0, sel} >= NUM_IN_C);

  logic [bitwidth-1:0] dch [0:stages];
  logic                vch [0:stages];
  logic [sel_w-1:0]    sch [0:stages];

  assign dch[0] = pick;
  assign vch[0] = in_valid;
  assign sch[0] = sel;

  for (genvar k = 0; k < stages; k++) begin : g_stage
    mux_pipe_stage #(
      .bitwidth (bitwidth),
      .sel_w    (sel_w)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .d_nxt (dch[k]),
      .v_nxt (vch[k]),
      .s_nxt (sch[k]),
      .d_q   (dch[k+1]),
      .v_q   (vch[k+1]),
      .s_q   (sch[k+1])
    );
  end

  assign out       = dch[stages];
  assign out_valid = vch[stages];
  assign sel_q     = sch[stages];

  // Not pipelined: flags one cycle after the bad select; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (en && in_valid && oor) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: table-driven single-stage vectors plus
// hand sequences for the two-stage pipeline, stalls and asynchronous reset.
module tb_mux_n_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  sel = '0;
  logic        err_clr = 1'b0;
  logic [127:0] bus4;
  logic [95:0]  bus3;

  logic [31:0] out1, out2, out3;
  logic        v1, v2, v3;
  logic [1:0]  s1, s2, s3;
  logic        e1, e2, e3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign bus4 = {32'h44, 32'h33, 32'h22, 32'h11};
  assign bus3 = bus4[95:0];

  mux_n_pipe #(.bitwidth(32), .num_in(4), .sel_w(2), .stages(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sel(sel), .in_bus(bus4),
    .err_clr(err_clr), .out(out1), .out_valid(v1), .sel_q(s1), .err_sticky(e1));

  mux_n_pipe #(.bitwidth(32), .num_in(4), .sel_w(2), .stages(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sel(sel), .in_bus(bus4),
    .err_clr(err_clr), .out(out2), .out_valid(v2), .sel_q(s2), .err_sticky(e2));

  mux_n_pipe #(.bitwidth(32), .num_in(3), .sel_w(2), .stages(1)) u3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sel(sel), .in_bus(bus3),
    .err_clr(err_clr), .out(out3), .out_valid(v3), .sel_q(s3), .err_sticky(e3));

  typedef struct {
    logic        en;
    logic        iv;
    logic [1:0]  sel;
    logic        clr;
    logic        chk_d;
    logic [31:0] e1_out;
    logic        e_v;
    logic [1:0]  e_s;
    logic [31:0] e3_out;
    logic        e3_err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic iv, input logic [1:0] s, input logic c);
    @(negedge clk);
    en = e; in_valid = iv; sel = s; err_clr = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; sel = '0; err_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //            en iv sel clr chk  u1 out  v  s   u3 out  err
    tbl[0]  = '{1, 1, 2, 0, 1, 32'h33, 1, 2, 32'h33, 0};
    tbl[1]  = '{1, 1, 0, 0, 1, 32'h11, 1, 0, 32'h11, 0};
    tbl[2]  = '{1, 1, 3, 0, 1, 32'h44, 1, 3, 32'h00, 1};
    tbl[3]  = '{0, 1, 1, 0, 1, 32'h44, 1, 3, 32'h00, 1};
    tbl[4]  = '{1, 0, 1, 1, 0, 32'h00, 0, 0, 32'h00, 0};
    tbl[5]  = '{1, 1, 1, 0, 1, 32'h22, 1, 1, 32'h22, 0};
    tbl[6]  = '{1, 0, 3, 0, 0, 32'h00, 0, 0, 32'h00, 0};
    tbl[7]  = '{0, 1, 3, 0, 0, 32'h00, 0, 0, 32'h00, 0};
    tbl[8]  = '{1, 1, 3, 0, 1, 32'h44, 1, 3, 32'h00, 1};
    tbl[9]  = '{1, 1, 3, 1, 1, 32'h44, 1, 3, 32'h00, 1};
    tbl[10] = '{1, 1, 2, 1, 1, 32'h33, 1, 2, 32'h33, 0};

    #1;
    chk("reset_out", out1, 32'h0);
    chk("reset_valid", {31'b0, v1}, 32'h0);
    chk("reset_sel_q", {30'b0, s1}, 32'h0);
    chk("reset_err", {31'b0, e3}, 32'h0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].en, tbl[i].iv, tbl[i].sel, tbl[i].clr);
      step();
      chk($sformatf("vec%0d_valid", i), {31'b0, v1}, {31'b0, tbl[i].e_v});
      chk($sformatf("vec%0d_valid3", i), {31'b0, v3}, {31'b0, tbl[i].e_v});
      chk($sformatf("vec%0d_err4", i), {31'b0, e1}, 32'h0);
      chk($sformatf("vec%0d_err3", i), {31'b0, e3}, {31'b0, tbl[i].e3_err});
      if (tbl[i].chk_d) begin
        chk($sformatf("vec%0d_out", i), out1, tbl[i].e1_out);
        chk($sformatf("vec%0d_sel_q", i), {30'b0, s1}, {30'b0, tbl[i].e_s});
        chk($sformatf("vec%0d_out3", i), out3, tbl[i].e3_out);
        chk($sformatf("vec%0d_sel_q3", i), {30'b0, s3}, {30'b0, tbl[i].e_s});
      end
    end

    // Two-stage: back-to-back samples emerge on cycles 2,3,4 contiguously.
    do_reset();
    drive(1, 1, 0, 0); step();
    chk("p2_c1_valid", {31'b0, v2}, 32'h0);
    drive(1, 1, 1, 0); step();
    chk("p2_c2_valid", {31'b0, v2}, 32'h1);
    chk("p2_c2_out", out2, 32'h11);
    chk("p2_c2_sel_q", {30'b0, s2}, 32'h0);
    drive(1, 1, 3, 0); step();
    chk("p2_c3_valid", {31'b0, v2}, 32'h1);
    chk("p2_c3_out", out2, 32'h22);
    chk("p2_c3_sel_q", {30'b0, s2}, 32'h1);
    drive(1, 0, 0, 0); step();
    chk("p2_c4_valid", {31'b0, v2}, 32'h1);
    chk("p2_c4_out", out2, 32'h44);
    chk("p2_c4_sel_q", {30'b0, s2}, 32'h3);
    chk("p2_err4", {31'b0, e2}, 32'h0);
    step();
    chk("p2_c5_valid", {31'b0, v2}, 32'h0);

    // Stall with a sample in flight in stage 1, then with one at the output.
    do_reset();
    drive(1, 1, 2, 0); step();
    chk("st_accept_valid", {31'b0, v2}, 32'h0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("st_hold%0d_valid", i), {31'b0, v2}, 32'h0);
    end
    drive(1, 0, 0, 0); step();
    chk("st_emerge_valid", {31'b0, v2}, 32'h1);
    chk("st_emerge_out", out2, 32'h33);
    chk("st_emerge_sel_q", {30'b0, s2}, 32'h2);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("st_frz%0d_valid", i), {31'b0, v2}, 32'h1);
      chk($sformatf("st_frz%0d_out", i), out2, 32'h33);
      chk($sformatf("st_frz%0d_sel_q", i), {30'b0, s2}, 32'h2);
    end
    drive(1, 0, 0, 0); step();
    chk("st_drain_valid", {31'b0, v2}, 32'h0);

    // Asynchronous reset mid-stream, checked between clock edges.
    drive(1, 1, 3, 0); step();
    drive(1, 1, 1, 0); step();
    chk("ar_pre_valid1", {31'b0, v1}, 32'h1);
    chk("ar_pre_valid2", {31'b0, v2}, 32'h1);
    chk("ar_pre_err3", {31'b0, e3}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out1", out1, 32'h0);
    chk("ar_valid1", {31'b0, v1}, 32'h0);
    chk("ar_sel_q1", {30'b0, s1}, 32'h0);
    chk("ar_valid2", {31'b0, v2}, 32'h0);
    chk("ar_out2", out2, 32'h0);
    chk("ar_err3", {31'b0, e3}, 32'h0);
    chk("ar_valid3", {31'b0, v3}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised, registered N-way datapath multiplexer for the multicycle CPU.
- Successor to the fixed 3-input combinational selector feeding the register file and PC, e.g. ALUResult/ALUOut/PC.
- Generalises input count and width, and adds 1- or 2-stage output registering, a valid/stall pipeline, and sticky detection of out-of-range selects.

Parameters:
- bitwidth, 32, data width of each input and of the output.
- num_in, 4, number of inputs (2..16).
- sel_w, 2, select width; must satisfy 2**sel_w >= num_in.
- stages, 1, output pipeline depth; legal values 1 or 2.
- default_val, 0, value driven for an out-of-range select.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 = stall, every stage holds.
- in_valid  input  1  qualifies sel/in_bus this cycle.
- sel  input  sel_w  input index.
- in_bus  input  num_in*bitwidth  flattened inputs; input i = in_bus[i*bitwidth +: bitwidth].
- err_clr  input  1  clears err_sticky.
- out  output  bitwidth  registered selected data (final stage).
- out_valid  output  1  out holds a valid sample.
- sel_q  output  sel_w  select value that produced out.
- err_sticky  output  1  set once an out-of-range select was accepted.

Behaviour:
- Reset (async, rst=1): out=0, out_valid=0, sel_q=0, err_sticky=0, all internal stages 0. Release is synchronous to clk.
- Combinational pick: sel < num_in -> input sel; otherwise default_val.
- Stage 1 on posedge clk with en=1:
  - d1 <= pick, v1 <= in_valid, s1 <= sel.
  - When in_valid=0, v1 <= 0 and d1/s1 still load; their value is don't-care and the bench checks data only when valid.
- stages=2: stage 2 loads from stage 1 on posedge with en=1.
- Outputs come from the last stage. Latency from accepted input to out_valid is exactly `stages` enabled cycles.
- en=0: all stages, including valid bits, hold. in_valid/sel are ignored that cycle and no input is accepted.
- err_sticky:
  - Sets on posedge when en=1, in_valid=1 and sel >= num_in.
  - Clears on posedge when err_clr=1.
  - Simultaneous set and clear: set wins, err_sticky=1.
  - The flag is not pipelined; it asserts one cycle after the bad select, independent of `stages`.
- Out-of-range with in_valid=1 still produces out_valid=1 and out=default_val. The consumer decides whether to use it.
- num_in = 2**sel_w: no out-of-range codes exist and err_sticky stays 0.
- Reset mid-stream: all in-flight samples are discarded and out_valid drops asynchronously.
- Illegal stages or sel_w values are rejected by an elaboration-time check (simulation $error), not handled at run time.
- No combinational path from any input to any output.

Decomposition:
- Shared package cpu_mux_pkg holds:
  - named select codes for existing users (SEL_ALURESULT=0, SEL_ALUOUT=1, SEL_PC=2);
  - the default pipeline depth constant;
  - a sel_w-from-num_in helper function.
- One sub-module, mux_pipe_stage: a parametrised register (bitwidth + sel_w + 1 valid) with async reset and enable, instantiated `stages` times in a generate loop.
- The pick logic and err_sticky stay in the top.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out, out_valid, sel_q and err_sticky read 0 immediately, without a clock edge.
- stages=1, num_in=4, bitwidth=32, inputs {0x11,0x22,0x33,0x44}, sel=2, in_valid=1 -> one cycle later out=0x33, sel_q=2, out_valid=1.
- stages=2: sel=0,1,3 on consecutive cycles -> out=0x11,0x22,0x44 on cycles 2,3,4, out_valid contiguous.
- Stall: en=0 for 3 cycles with a sample in flight -> out, out_valid and sel_q frozen; after en=1 the sample emerges with unchanged latency.
- num_in=3, sel=3, in_valid=1 -> out=default_val (0), out_valid=1, err_sticky=1 next cycle. Hold err_clr=1 together with another sel=3 -> err_sticky stays 1. Then err_clr=1 with a valid sel -> err_sticky=0.
- num_in=3, sel=3 with in_valid=0 -> err_sticky stays 0 and out_valid=0.
